// File: rtl/coprocessor_pkg.sv
// Shared definitions for the coprocessor datapath.
//   WORD_WIDTH            : element width (IEEE-754 binary32 only)
//   EXP_MSB/EXP_LSB       : exponent field bounds of a binary32 word
//   MAN_MSB               : top bit of the mantissa field
//   exc_t                 : 2-bit exception class, bit1 = NaN, bit0 = Inf
//   ser_state_t           : result serializer states
package coprocessor_pkg;

  localparam int WORD_WIDTH = 32;

  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_MSB = 22;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_INF  = 2'b01,
    EXC_NAN  = 2'b10
  } exc_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational binary32 classifier.
//   value : 32-bit IEEE-754 single-precision word
//   exc   : EXC_NAN when exponent is all ones and mantissa non-zero,
//           EXC_INF when exponent is all ones and mantissa zero,
//           EXC_NONE otherwise. The sign bit does not matter.
module fp32_classify
  import coprocessor_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] value,
  output exc_t                  exc
);

  logic [EXP_MSB-EXP_LSB:0] exponent;
  logic [MAN_MSB:0]         mantissa;
  logic                     sign_unused;

  assign exponent    = value[EXP_MSB:EXP_LSB];
  assign mantissa    = value[MAN_MSB:0];
  assign sign_unused = value[WORD_WIDTH-1];

  always_comb begin
    exc = EXC_NONE;
    if (exponent == '1) begin
      exc = (mantissa != '0) ? EXC_NAN : EXC_INF;
    end
  end

endmodule

// File: rtl/matrix_result_serializer.sv
// Serializes the 2x2 result matrix of the matrix adder onto a one-word
// valid/ready stream, row-major, with a per-word exception class.
//
// Ports:
//   clock, reset       : single clock, synchronous active-high reset
//   done               : adder done level; a 0->1 edge captures result_*
//   result_00..11      : adder results, stable while done is high
//   out_data/index/last/exc, out_valid, out_ready : output stream
//   busy               : high while a captured matrix is still being sent
//                        (direct view of the state register, SEND = 1)
//   overrun            : sticky flag, a done edge was dropped
//   clear_overrun      : synchronous clear of overrun (a same-edge drop wins)
//
// Handshake: a word transfers on a rising clock edge where out_valid and
// out_ready are both high. out_valid never depends on out_ready, and while
// out_valid is high and out_ready low every out_* signal holds stable. When
// out_valid is low the out_* payload holds its last value.
module matrix_result_serializer #(
  parameter int WORD_WIDTH = coprocessor_pkg::WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  done,
  input  logic [WORD_WIDTH-1:0] result_00,
  input  logic [WORD_WIDTH-1:0] result_01,
  input  logic [WORD_WIDTH-1:0] result_10,
  input  logic [WORD_WIDTH-1:0] result_11,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [1:0]            out_index,
  output logic                  out_last,
  output logic [1:0]            out_exc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  clear_overrun
);

  import coprocessor_pkg::*;

  // Element i of these arrays is matrix position i in row-major order.
  logic [3:0][WORD_WIDTH-1:0] res_in;
  exc_t                       res_cls [4];

  ser_state_t                 state_q, state_d;
  logic                       done_q, done_d;
  logic [3:0][WORD_WIDTH-1:0] buf_q, buf_d;
  logic [3:0][1:0]            exc_q, exc_d;
  logic [1:0]                 idx_q, idx_d;
  logic                       overrun_q, overrun_d;

  logic capture;
  logic xfer;
  logic final_xfer;
  logic dropped;

  assign res_in = {result_11, result_10, result_01, result_00};

  for (genvar i = 0; i < 4; i++) begin : g_cls
    fp32_classify u_cls (
      .value (res_in[i]),
      .exc   (res_cls[i])
    );
  end

  assign capture    = done & ~done_q;
  assign xfer       = (state_q == SEND) & out_ready;
  assign final_xfer = xfer & (idx_q == 2'd3);
  // A capture while words are still owed is lost, except on the edge that
  // hands over the last word: that slot is free again, so it is taken.
  assign dropped    = capture & (state_q == SEND) & ~final_xfer;

  always_comb begin
    state_d   = state_q;
    done_d    = done;
    buf_d     = buf_q;
    exc_d     = exc_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;

    if (clear_overrun) begin
      overrun_d = 1'b0;
    end
    if (dropped) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          idx_d   = 2'd0;
          buf_d   = res_in;
          for (int i = 0; i < 4; i++) begin
            exc_d[i] = res_cls[i];
          end
        end
      end
      SEND: begin
        if (final_xfer) begin
          if (capture) begin
            idx_d = 2'd0;
            buf_d = res_in;
            for (int i = 0; i < 4; i++) begin
              exc_d[i] = res_cls[i];
            end
          end else begin
            // Index stays at 3 so the idle outputs keep showing the
            // last word that was handed over.
            state_d = IDLE;
          end
        end else if (xfer) begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      done_q    <= 1'b1;  // a done level held across reset is not an edge
      buf_q     <= '0;
      exc_q     <= '0;
      idx_q     <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      buf_q     <= buf_d;
      exc_q     <= exc_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_data  = buf_q[idx_q];
  assign out_exc   = exc_q[idx_q];
  assign out_index = idx_q;
  assign out_last  = (idx_q == 2'd3);
  assign overrun   = overrun_q;

endmodule

// File: doc/matrix_result_serializer.md
# matrix_result_serializer

Downstream stage of the coprocessor's 2×2 single-precision matrix adder.
- Captures the four 32-bit result elements on each rising edge of the adder's `done`.
- Classifies each element as NaN, Inf, or ordinary.
- Streams the elements out one word per transfer, row-major, over a valid/ready interface, so a narrow bus or writeback unit can consume them without holding the adder.

## Interface
Parameters:
- `WORD_WIDTH`, 32: element width; only 32 (IEEE-754 binary32) is supported.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clock` rising edge.
- `done`  in  1  level from the adder; a 0→1 transition marks new valid results.
- `result_00`, `result_01`, `result_10`, `result_11`  in  32 each  adder outputs; stable while `done` is high.
- `out_data`  out  32  current element.
- `out_index`  out  2  element position: 0=00, 1=01, 2=10, 3=11.
- `out_last`  out  1  high with element 3.
- `out_exc`  out  2  class of `out_data`: bit1=NaN, bit0=Inf.
- `out_valid`  out  1  `out_data`, `out_index`, `out_last` and `out_exc` are valid.
- `out_ready`  in  1  consumer accepts the word when high together with `out_valid`.
- `busy`  out  1  a captured matrix is not yet fully transferred.
- `overrun`  out  1  sticky; set when a `done` edge is dropped.
- `clear_overrun`  in  1  synchronous clear of `overrun`.

## Operation
- Edge detect: `done_q` is a register holding the previous `done`. A capture event is `done & ~done_q`.
- `done_q` resets to 1. A `done` held high through reset is therefore not captured; only a genuine 0→1 edge after reset is.
- State machine has two states, IDLE and SEND.
  - IDLE: on a capture event, register all four results. Register four 2-bit exception codes (from `fp32_classify`). Set index to 0. Go to SEND.
  - SEND: `out_valid`=1. On `out_valid & out_ready`, index increments.
  - On the transfer at index 3, return to IDLE, unless a capture event occurs on the same edge. In that case, capture the new matrix, set index to 0, and stay in SEND.
- Overrun: a capture event in SEND, other than on the final-transfer edge, is dropped. The buffered data is untouched and `overrun` is set on that edge.
  - `clear_overrun` clears `overrun` on the next edge.
  - If a dropped capture and `clear_overrun` occur on the same edge, set wins.
- Classification of each element:
  - NaN: exponent[30:23]=8'hFF and mantissa[22:0]≠0.
  - Inf: exponent=8'hFF and mantissa=0.
  - Otherwise 2'b00. The sign bit is ignored.
- Output registers:
  - `out_data`, `out_index`, `out_last` and `out_exc` are driven from registered buffer and index state; there is no combinational path from `result_*`.
  - While `out_valid` is low, these outputs hold their last values.
- `busy` equals the SEND state.

## Timing
- Reset values: `out_valid`=0, `busy`=0, `overrun`=0, `out_index`=0, `out_last`=0, `out_data`=0, `out_exc`=0, state=IDLE, `done_q`=1.
- Latency: a capture event sampled at edge k gives `out_valid`=1 in the cycle after edge k, presenting element 00.
- Throughput: one word per cycle with `out_ready` held high, so 4 cycles per matrix. The back-to-back capture case (same-edge capture) adds no bubble.
- Stall: while `out_valid=1` and `out_ready=0`, all output signals hold stable.
- Reset mid-stream: on the reset edge, `out_valid` drops, the buffer is discarded, and `overrun` clears. Any word not yet accepted is lost.
- `out_ready` does not influence anything while in IDLE.

## Structure
- Shared package `coprocessor_pkg` holds:
  - `WORD_WIDTH`;
  - FP32 field constants `EXP_MSB`=30, `EXP_LSB`=23, `MAN_MSB`=22;
  - the `exc_t` encoding (`EXC_NONE`, `EXC_INF`, `EXC_NAN`);
  - the state enum `ser_state_t` (IDLE, SEND).
- Sub-module `fp32_classify`: combinational, input 32 bits, output 2-bit `exc_t`. Instantiated four times, on the `result_*` inputs, at capture.
- Expected size: about 150–220 lines of RTL.

## Test plan
- Basic stream:
  - Stimulus: results 0x40B8C28F, 0x40400000, 0x40400000, 0x40400000; pulse `done`; `out_ready`=1.
  - Response: 4 consecutive words in that order, indices 0–3, `out_last` only on the 4th, `out_exc`=0, `busy` falls after the 4th transfer.
- Back-pressure:
  - Stimulus: `out_ready` toggled 1,0,0,1,0,1,1.
  - Response: each word held stable while stalled; exactly 4 transfers; no duplicated or skipped index.
- Exceptions:
  - Stimulus: results 0x7FC00000, 0x7F800000, 0xFF800000, 0x3F800000.
  - Response: `out_exc`=2'b10, 01, 01, 00.
- Overrun:
  - Stimulus: a second `done` edge while element 1 is pending.
  - Response: `overrun`=1, the original 4 words are delivered unchanged. `clear_overrun` then gives `overrun`=0.
- Same-edge recapture:
  - Stimulus: new `done` edge on the edge where element 3 transfers.
  - Response: no overrun; the new matrix's element 00 appears on the next cycle.
- Reset:
  - Stimulus: assert `reset` while element 2 is pending, with `done` held high throughout.
  - Response: `out_valid`=0 and no capture after release until `done` falls and rises again.
